bus_select_encoder: RTL

//  Driver-side partner of the datapath bus multiplexer. Takes the control unit's one-hot
//  "<src>out" enables and produces the 5-bit select code S that steers the mux.

---
 rtl/bus_select_encoder.sv | 96 +++++++++
 1 files changed

// File: rtl/bus_select_encoder.sv
// bus_select_encoder: priority-encodes one-hot bus enables into a registered mux select with conflict tracking.
// Optional drive statistics counter enabled by BUS_SEL_ENC_STATS_EN.
module bus_select_encoder #(
    parameter int NSRC             = 24,
    parameter int SEL_W            = 5,
    parameter int CNT_W            = 8,
    parameter int HALT_ON_CONFLICT = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [NSRC-1:0]  out_en,
    input  logic             conflict_ack,
    output logic [SEL_W-1:0] S,
    output logic             bus_valid,
    output logic             conflict,
    output logic             conflict_seen,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic             fault
`ifdef BUS_SEL_ENC_STATS_EN
    ,
    output logic [15:0]      drive_cnt
`endif
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] DRIVE = 2'b01;
    localparam logic [1:0] FAULT = 2'b10;
    localparam bit HALT = HALT_ON_CONFLICT != 0;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d, win;
    logic             valid_q, valid_d;
    logic             conflict_q, seen_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             any, multi;

    assign any   = |out_en;
    assign multi = (out_en & (out_en - 1'b1)) != '0;

    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (out_en[i]) win = SEL_W'(i);
    end

    // FAULT ignores enables entirely; the entry cycle itself still latches the winner
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        valid_d = 1'b0;
        if (state_q == FAULT) begin
            state_d = conflict_ack ? IDLE : FAULT;
        end else if (any) begin
            state_d = (multi && HALT) ? FAULT : DRIVE;
            s_d     = win;
            valid_d = !(multi && HALT);
        end else begin
            state_d = IDLE;
        end
    end

    assign cnt_d = cnt_q + CNT_W'(multi && !(&cnt_q));

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            s_q        <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            seen_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            valid_q    <= valid_d;
            conflict_q <= multi;
            seen_q     <= seen_q | multi;
            cnt_q      <= cnt_d;
        end
    end

    assign S             = s_q;
    assign bus_valid     = valid_q;
    assign conflict      = conflict_q;
    assign conflict_seen = seen_q;
    assign conflict_cnt  = cnt_q;
    assign fault         = state_q == FAULT;

`ifdef BUS_SEL_ENC_STATS_EN
    logic [15:0] drive_q;
    always_ff @(posedge clock) begin
        if (clear) drive_q <= '0;
        else drive_q <= drive_q + 16'(valid_d);
    end
    assign drive_cnt = drive_q;
`endif
endmodule
